// File: rtl/fp32_sq_issue.sv
// fp32_sq_issue
// Operand issuer ahead of the fp32 multiplier in the r^2 path. Buffers
// displacement vectors {dx, dy, dz, tag} in a circular FIFO and issues each
// vector as three squaring pairs (dx*dx, dy*dy, dz*dz). Each pair goes out on a
// valid/ready handshake, together with the component index and the tag.
//
// Optional feature macro: FP32_SQ_DAZ_EN. When it is defined, any issued operand
// whose exponent field is zero is flushed to a signed zero. The flush is applied
// at the output mux, so the stored data is left unchanged.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready      upstream vector handshake
//   in_dx, in_dy, in_dz      fp32 displacement components
//   in_tag                   pair identifier (TAG_W bits), passed through
//   out_valid / out_ready    downstream operand-pair handshake
//   out_a, out_b             multiplier operands (always equal)
//   out_comp                 component index 0 = x, 1 = y, 2 = z
//   out_last                 high on the z component
//   out_tag                  tag of the head vector
//   level                    number of vectors currently stored
module fp32_sq_issue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_dx,
    input  logic [31:0]                in_dy,
    input  logic [31:0]                in_dz,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_a,
    output logic [31:0]                out_b,
    output logic [1:0]                 out_comp,
    output logic                       out_last,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        COMP_X   = 2'd0,
        COMP_Y   = 2'd1,
        COMP_Z   = 2'd2,
        COMP_BAD = 2'd3
    } comp_e;

    logic [31:0]      mem_dx  [DEPTH];
    logic [31:0]      mem_dy  [DEPTH];
    logic [31:0]      mem_dz  [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    comp_e            comp_q, comp_d;

    logic        push, hs, pop;
    logic [31:0] sel_op;

    // The full flag depends only on the registered level, so a pop cannot open
    // a slot for a push in the same cycle.
    assign in_ready  = (level_q != LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready;
    assign hs        = out_valid && out_ready;
    assign pop       = hs && (comp_q == COMP_Z);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Component sequencer. It moves forward only on a handshake. The unused
    // encoding falls back to X.
    always_comb begin
        comp_d = comp_q;
        case (comp_q)
            COMP_X:  if (hs) comp_d = COMP_Y;
            COMP_Y:  if (hs) comp_d = COMP_Z;
            COMP_Z:  if (hs) comp_d = COMP_X;
            default: comp_d = COMP_X;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            comp_q   <= COMP_X;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            comp_q   <= comp_d;
        end
    end

    // Storage has no reset. Entries are read only after they have been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dx[wr_ptr_q]  <= in_dx;
            mem_dy[wr_ptr_q]  <= in_dy;
            mem_dz[wr_ptr_q]  <= in_dz;
            mem_tag[wr_ptr_q] <= in_tag;
        end
    end

    always_comb begin
        case (comp_q)
            COMP_Y:  sel_op = mem_dy[rd_ptr_q];
            COMP_Z:  sel_op = mem_dz[rd_ptr_q];
            default: sel_op = mem_dx[rd_ptr_q];
        endcase
    end

`ifdef FP32_SQ_DAZ_EN
    always_comb begin
        out_a = sel_op;
        if (sel_op[30:23] == 8'h00) out_a = {sel_op[31], 31'b0};
    end
`else
    assign out_a = sel_op;
`endif

    assign out_b    = out_a;
    assign out_comp = comp_q;
    assign out_last = (comp_q == COMP_Z);
    assign out_tag  = mem_tag[rd_ptr_q];
    assign level    = level_q;

endmodule

// File: tb/tb_fp32_sq_issue.sv
module tb_fp32_sq_issue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_dx = '0, in_dy = '0, in_dz = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_a, out_b;
    logic [1:0]       out_comp;
    logic             out_last;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       level;

    fp32_sq_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dx(in_dx), .in_dy(in_dy), .in_dz(in_dz), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_comp(out_comp),
        .out_last(out_last), .out_tag(out_tag), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      a;
        logic [1:0]       comp;
        logic             last;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_op(input logic [31:0] v);
        logic [31:0] r;
        r = v;
`ifdef FP32_SQ_DAZ_EN
        if (v[30:23] == 8'h00) r = {v[31], 31'b0};
`endif
        return r;
    endfunction

    // Scoreboard: compare the issued pairs, then record newly accepted vectors.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("out_a",    out_a,             e.a);
                check("out_b",    out_b,             e.a);
                check("out_comp", {30'b0, out_comp}, {30'b0, e.comp});
                check("out_last", {31'b0, out_last}, {31'b0, e.last});
                check("out_tag",  {24'b0, out_tag},  {24'b0, e.tag});
            end
        end
        if (!rst && in_valid && in_ready) begin
            sb.push_back('{a: model_op(in_dx), comp: 2'd0, last: 1'b0, tag: in_tag});
            sb.push_back('{a: model_op(in_dy), comp: 2'd1, last: 1'b0, tag: in_tag});
            sb.push_back('{a: model_op(in_dz), comp: 2'd2, last: 1'b1, tag: in_tag});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] dx, input logic [31:0] dy,
                         input logic [31:0] dz, input logic [TAG_W-1:0] tag);
        in_dx = dx; in_dy = dy; in_dz = dz; in_tag = tag; in_valid = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (out_valid === 1'b1 || sb.size() != 0); i++) tick();
        check("drain_valid", {31'b0, out_valid}, 32'd0);
        check("drain_level", {29'b0, level}, 32'd0);
        check("drain_sb", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #2;
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_level",     {29'b0, level},     32'd0);
        check("rst_out_comp",  {30'b0, out_comp},  32'd0);
        check("rst_out_last",  {31'b0, out_last},  32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single vector
        out_ready = 1'b1;
        drive(32'h3F800000, 32'h40000000, 32'hC0400000, 8'h15);
        tick();
        in_valid = 1'b0;
        check("sv_valid0", {31'b0, out_valid}, 32'd1);
        check("sv_comp0",  {30'b0, out_comp},  32'd0);
        check("sv_a0",     out_a,              32'h3F800000);
        check("sv_last0",  {31'b0, out_last},  32'd0);
        tick();
        check("sv_comp1",  {30'b0, out_comp},  32'd1);
        check("sv_a1",     out_a,              32'h40000000);
        tick();
        check("sv_comp2",  {30'b0, out_comp},  32'd2);
        check("sv_last2",  {31'b0, out_last},  32'd1);
        check("sv_tag2",   {24'b0, out_tag},   32'h15);
        tick();
        check("sv_valid3", {31'b0, out_valid}, 32'd0);
        check("sv_level3", {29'b0, level},     32'd0);

        // Backpressure at the y component
        drive(32'h3F000000, 32'h40000000, 32'h40400000, 8'h22);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_comp", {30'b0, out_comp}, 32'd1);
            check("bp_a",    out_a,             32'h40000000);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_next_z", {30'b0, out_comp}, 32'd2);
        check("bp_next_a", out_a,             32'h40400000);
        drain();

        // Full FIFO with no bypass
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("full_rdy_pre", {31'b0, in_ready}, 32'd1);
            drive(32'h3F800000 + 32'(i), 32'h40000000 + 32'(i), 32'h40800000 + 32'(i), TAG_W'(i));
            tick();
        end
        check("full_level", {29'b0, level},    32'd4);
        check("full_rdy",   {31'b0, in_ready}, 32'd0);
        drive(32'h41000005, 32'h41100005, 32'h41200005, 8'd5);
        tick();
        check("full_hold_level", {29'b0, level}, 32'd4);
        out_ready = 1'b1;
        tick(); tick();
        check("full_rdy_before_pop", {31'b0, in_ready}, 32'd0);
        tick();
        check("full_level_after_pop", {29'b0, level},    32'd3);
        check("full_rdy_after_pop",   {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("full_tag5_accepted", {29'b0, level}, 32'd4);
        drain();

        // Push on the z handshake while two vectors are queued, across pointer wrap
        out_ready = 1'b0;
        drive($urandom, $urandom, $urandom, 8'h30);
        tick();
        drive($urandom, $urandom, $urandom, 8'h31);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            tick(); tick();
            drive($urandom, $urandom, $urandom, TAG_W'(8'h40 + k));
            tick();
            in_valid = 1'b0;
            check("pp_level", {29'b0, level},    32'd2);
            check("pp_comp",  {30'b0, out_comp}, 32'd0);
        end
        drain();

        // Reset while the y component of a vector is pending
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, $urandom, TAG_W'(8'h60 + i));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mid_comp_y", {30'b0, out_comp}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_valid", {31'b0, out_valid}, 32'd0);
        check("mid_level", {29'b0, level},     32'd0);
        check("mid_comp",  {30'b0, out_comp},  32'd0);
        check("mid_rdy",   {31'b0, in_ready},  32'd1);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        drive(32'h3E800000, 32'h3F400000, 32'h3FC00000, 8'h7A);
        tick();
        in_valid = 1'b0;
        check("post_rst_comp", {30'b0, out_comp}, 32'd0);
        check("post_rst_tag",  {24'b0, out_tag},  32'h7A);
        drain();

        // Denormal operands
        drive(32'h00000001, 32'h80400000, 32'h3F800000, 8'h55);
        tick();
        in_valid = 1'b0;
`ifdef FP32_SQ_DAZ_EN
        check("daz_x", out_a, 32'h00000000);
        tick();
        check("daz_y", out_a, 32'h80000000);
`else
        check("daz_x", out_a, 32'h00000001);
        tick();
        check("daz_y", out_a, 32'h80400000);
`endif
        tick();
        check("daz_z", out_a, 32'h3F800000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
